// File: rtl/idct_block_fetcher_pkg.sv
// Shared types and SRAM map constants for the IDCT fetch/write-back stages.
package idct_block_fetcher_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WAIT_BANK,
        S_DONE
    } fetch_state_e;

    typedef enum logic [1:0] {
        PLANE_Y,
        PLANE_U,
        PLANE_V
    } plane_e;

    localparam int unsigned PRE_IDCT_BASE_ADDR  = 76800;
    localparam int unsigned PRE_IDCT_ROW_STRIDE = 320;
    localparam int unsigned Y_BASE_ADDR         = 0;
    localparam int unsigned U_BASE_ADDR         = 38400;
    localparam int unsigned V_BASE_ADDR         = 57600;

    // {bank, row, col} address into the two-bank block buffer
    function automatic int buf_addr_width(input int block_dim);
        return 1 + 2 * $clog2(block_dim);
    endfunction

    function automatic int unsigned plane_base(input plane_e plane);
        case (plane)
            PLANE_U: return U_BASE_ADDR;
            PLANE_V: return V_BASE_ADDR;
            default: return Y_BASE_ADDR;
        endcase
    endfunction

endpackage

// File: rtl/idct_block_fetcher_tag_pipe.sv
// sram_tag_pipe: LATENCY-deep valid+tag shift register that follows SRAM reads
// so returning data can be paired with its destination.
module sram_tag_pipe #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             empty_o
);

    logic [LATENCY-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [LATENCY];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= push_i;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // NOTE: the tag array is deliberately left without reset; a stale tag is harmless because valid_q gates it.
    always_ff @(posedge clk_i) begin
        tag_q[0] <= tag_i;
        for (int i = 1; i < LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign tag_o   = tag_q[LATENCY-1];
    assign empty_o = ~|valid_q;

endmodule

// File: rtl/idct_block_fetcher.sv
// Walks the pre-IDCT coefficient image block by block, one SRAM read per cycle,
// filling a ping-pong block buffer for the matrix-multiply stage.
module idct_block_fetcher
    import idct_block_fetcher_pkg::*;
#(
    parameter int BLOCK_DIM      = 8,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int BASE_ADDR      = PRE_IDCT_BASE_ADDR,
    parameter int ROW_STRIDE     = PRE_IDCT_ROW_STRIDE,
    parameter int BLOCKS_PER_ROW = 40,
    parameter int BLOCK_ROWS     = 30,
    parameter int SRAM_LATENCY   = 2
) (
    input  logic                                   Clock,
    input  logic                                   Reset,
    input  logic                                   Start,
    output logic [ADDR_W-1:0]                      SRAM_address,
    input  logic [DATA_W-1:0]                      SRAM_read_data,
    output logic                                   SRAM_we_n,
    output logic [buf_addr_width(BLOCK_DIM)-1:0]   Buf_address,
    output logic [DATA_W-1:0]                      Buf_write_data,
    output logic                                   Buf_we,
    output logic [1:0]                             Bank_full,
    input  logic [1:0]                             Bank_release,
    output logic                                   Busy,
    output logic                                   Done
);

    localparam int CW     = $clog2(BLOCK_DIM);
    localparam int TAG_W  = 1 + 2 * CW;
    localparam int BCW    = $clog2(BLOCKS_PER_ROW + 1);
    localparam int BRW    = $clog2(BLOCK_ROWS + 1);
    localparam logic [ADDR_W-1:0] BLOCK_STEP    = ADDR_W'(BLOCK_DIM);
    localparam logic [ADDR_W-1:0] ROW_WRAP_STEP =
        ADDR_W'(BLOCK_DIM * ROW_STRIDE - (BLOCKS_PER_ROW - 1) * BLOCK_DIM);
    localparam longint LAST_ADDR = longint'(BASE_ADDR)
        + longint'(BLOCK_ROWS * BLOCK_DIM - 1) * longint'(ROW_STRIDE)
        + longint'(BLOCKS_PER_ROW * BLOCK_DIM - 1);

    fetch_state_e      state_q, state_d;
    logic              bank_q, bank_d;
    logic [BCW-1:0]    block_col_q, block_col_d;
    logic [BRW-1:0]    block_row_q, block_row_d;
    logic [ADDR_W-1:0] block_base_q, block_base_d;
    logic [ADDR_W-1:0] row_off_q, row_off_d;
    logic [CW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic [1:0]        set_mask;
    logic              push;
    logic              next_bank;

    logic              buf_we_q;
    logic [TAG_W-1:0]  buf_addr_q;
    logic [DATA_W-1:0] buf_data_q;

    logic              tag_valid;
    logic [TAG_W-1:0]  tag_out;
    logic              pipe_empty;

    sram_tag_pipe #(
        .LATENCY (SRAM_LATENCY),
        .TAG_W   (TAG_W)
    ) u_tag_pipe (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .push_i  (push),
        .tag_i   ({bank_q, row_q, col_q}),
        .valid_o (tag_valid),
        .tag_o   (tag_out),
        .empty_o (pipe_empty)
    );

    assign next_bank = ~bank_q;

    // NOTE: every combinational output gets its default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        block_col_d  = block_col_q;
        block_row_d  = block_row_q;
        block_base_d = block_base_q;
        row_off_d    = row_off_q;
        row_d        = row_q;
        col_d        = col_q;
        set_mask     = 2'b00;
        push         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d      = S_FETCH;
                    bank_d       = 1'b0;
                    block_col_d  = '0;
                    block_row_d  = '0;
                    block_base_d = ADDR_W'(BASE_ADDR);
                    row_off_d    = '0;
                    row_d        = '0;
                    col_d        = '0;
                end
            end
            S_FETCH: begin
                push  = 1'b1;
                col_d = col_q + 1'b1;
                if (col_q == CW'(BLOCK_DIM - 1)) begin
                    row_d     = row_q + 1'b1;
                    row_off_d = row_off_q + ADDR_W'(ROW_STRIDE);
                    if (row_q == CW'(BLOCK_DIM - 1)) begin
                        row_off_d = '0;
                        state_d   = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pipe_empty) begin
                    set_mask[bank_q] = 1'b1;
                    bank_d           = next_bank;
                    if (block_col_q == BCW'(BLOCKS_PER_ROW - 1)) begin
                        block_col_d  = '0;
                        block_row_d  = block_row_q + 1'b1;
                        block_base_d = block_base_q + ROW_WRAP_STEP;
                    end else begin
                        block_col_d  = block_col_q + 1'b1;
                        block_base_d = block_base_q + BLOCK_STEP;
                    end
                    if (block_row_q == BRW'(BLOCK_ROWS - 1) &&
                        block_col_q == BCW'(BLOCKS_PER_ROW - 1)) begin
                        state_d = S_DONE;
                    end else if (bank_full_q[next_bank] && !Bank_release[next_bank]) begin
                        state_d = S_WAIT_BANK;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WAIT_BANK: begin
                // a release arriving this cycle frees the bank in time for next-cycle fetch
                if (!bank_full_q[bank_q] || Bank_release[bank_q]) begin
                    state_d = S_FETCH;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // set beats a simultaneous release of the same bank
        bank_full_d = (bank_full_q & ~Bank_release) | set_mask;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            bank_q       <= 1'b0;
            block_col_q  <= '0;
            block_row_q  <= '0;
            block_base_q <= '0;
            row_off_q    <= '0;
            row_q        <= '0;
            col_q        <= '0;
            bank_full_q  <= 2'b00;
            buf_we_q     <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            block_col_q  <= block_col_d;
            block_row_q  <= block_row_d;
            block_base_q <= block_base_d;
            row_off_q    <= row_off_d;
            row_q        <= row_d;
            col_q        <= col_d;
            bank_full_q  <= bank_full_d;
            buf_we_q     <= tag_valid;
            if (tag_valid) begin
                buf_addr_q <= tag_out;
                buf_data_q <= SRAM_read_data;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            assert (LAST_ADDR < (longint'(1) << ADDR_W));
            assert ((BLOCK_DIM & (BLOCK_DIM - 1)) == 0 && BLOCK_DIM >= 4 && BLOCK_DIM <= 16);
        end
    end

    assign SRAM_address   = block_base_q + row_off_q + ADDR_W'(col_q);
    assign SRAM_we_n      = 1'b1;
    assign Buf_address    = buf_addr_q;
    assign Buf_write_data = buf_data_q;
    assign Buf_we         = buf_we_q;
    assign Bank_full      = bank_full_q;
    assign Busy           = (state_q != S_IDLE);
    assign Done           = (state_q == S_DONE);

endmodule

// File: tb/tb_idct_block_fetcher.sv
// Scoreboard bench for idct_block_fetcher on a 2x2-block image of 8x8 blocks
// in the default SRAM map; the SRAM model returns address[15:0] after 2 cycles.
module tb_idct_block_fetcher;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int BUF_AW = 7;

    typedef struct {
        logic [BUF_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              Start;
    logic [ADDR_W-1:0] SRAM_address;
    logic [DATA_W-1:0] SRAM_read_data;
    logic              SRAM_we_n;
    logic [BUF_AW-1:0] Buf_address;
    logic [DATA_W-1:0] Buf_write_data;
    logic              Buf_we;
    logic [1:0]        Bank_full;
    logic [1:0]        Bank_release = 2'b00;
    logic              Busy;
    logic              Done;

    int   checks = 0;
    int   errors = 0;
    int   we_count = 0;
    int   done_count = 0;
    exp_t exp_q[$];
    logic auto_rel = 1'b1;
    logic [1:0] manual_rel = 2'b00;
    int   block_base_tbl[4] = '{76800, 76808, 79360, 79368};

    always #5 Clock = ~Clock;

    idct_block_fetcher #(
        .BLOCK_DIM      (8),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .BASE_ADDR      (76800),
        .ROW_STRIDE     (320),
        .BLOCKS_PER_ROW (2),
        .BLOCK_ROWS     (2),
        .SRAM_LATENCY   (2)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Start          (Start),
        .SRAM_address   (SRAM_address),
        .SRAM_read_data (SRAM_read_data),
        .SRAM_we_n      (SRAM_we_n),
        .Buf_address    (Buf_address),
        .Buf_write_data (Buf_write_data),
        .Buf_we         (Buf_we),
        .Bank_full      (Bank_full),
        .Bank_release   (Bank_release),
        .Busy           (Busy),
        .Done           (Done)
    );

    logic [DATA_W-1:0] sram_d1, sram_d2;
    always @(posedge Clock) begin
        sram_d1 <= SRAM_address[15:0];
        sram_d2 <= sram_d1;
    end
    assign SRAM_read_data = sram_d2;

    always @(negedge Clock) begin
        if (auto_rel) Bank_release = Bank_full[0] ? 2'b01 : (Bank_full[1] ? 2'b10 : 2'b00);
        else Bank_release = manual_rel;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge Clock);
            if (Done === 1'b1) done_count++;
            if (Buf_we === 1'b1) begin
                we_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(Buf_address), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("buf_addr", 32'(Buf_address), 32'(e.addr));
                    check("buf_data", 32'(Buf_write_data), 32'(e.data));
                end
            end
        end
    endtask

    task automatic push_block(input int bank, input int blk);
        exp_t e;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                e.addr = BUF_AW'((bank << 6) | (r << 3) | c);
                e.data = DATA_W'(block_base_tbl[blk] + r * 320 + c);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_pulse();
        @(negedge Clock);
        Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
    endtask

    task automatic reset_dut();
        Reset = 1'b1;
        @(posedge Clock);
        #1 exp_q.delete();
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
    endtask

    task automatic run_full_image();
        int n;
        we_count   = 0;
        done_count = 0;
        auto_rel   = 1'b1;
        push_block(0, 0);
        push_block(1, 1);
        push_block(0, 2);
        push_block(1, 3);
        start_pulse();
        check("first_addr", 32'(SRAM_address), 76800);
        check("busy_after_start", 32'(Busy), 1);
        @(posedge Clock); #1 check("second_addr", 32'(SRAM_address), 76801);
        @(posedge Clock); #1 check("no_write_before_latency", 32'(Buf_we), 0);
        @(posedge Clock); #1 check("first_write_latency", 32'(Buf_we), 1);
        repeat (4) @(posedge Clock);
        #1 check("row0_last_addr", 32'(SRAM_address), 76807);
        @(posedge Clock); #1 check("row1_first_addr", 32'(SRAM_address), 77120);
        repeat (58) @(posedge Clock);
        #1 check("bank0_not_full_at_66", 32'(Bank_full), 0);
        @(posedge Clock); #1 check("bank0_full_at_67", 32'(Bank_full), 1);
        check("block1_first_addr", 32'(SRAM_address), 76808);
        repeat (10) @(posedge Clock);
        #1 Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        n = 0;
        while (done_count == 0 && n < 1000) begin
            @(posedge Clock);
            #1 n++;
        end
        check("done_within_budget", 32'(n < 1000), 1);
        repeat (20) @(posedge Clock);
        #1 check("busy_low_after_done", 32'(Busy), 0);
        check("single_done_pulse", done_count, 1);
        check("write_count", we_count, 256);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int changes;
        int writes;
        logic [ADDR_W-1:0] hold;

        Reset = 1'b1;
        Start = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge Clock);
        #1;
        check("rst_sram_addr", 32'(SRAM_address), 0);
        check("rst_we_n", 32'(SRAM_we_n), 1);
        check("rst_buf_we", 32'(Buf_we), 0);
        check("rst_buf_addr", 32'(Buf_address), 0);
        check("rst_buf_data", 32'(Buf_write_data), 0);
        check("rst_bank_full", 32'(Bank_full), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);
        Reset = 1'b0;

        run_full_image();

        // consumer holds both banks: fetcher must stall until bank 0 is released
        reset_dut();
        auto_rel   = 1'b0;
        manual_rel = 2'b00;
        push_block(0, 0);
        push_block(1, 1);
        push_block(0, 2);
        start_pulse();
        n = 0;
        while (Bank_full != 2'b11 && n < 500) begin
            @(posedge Clock);
            #1 n++;
        end
        check("both_banks_full", 32'(Bank_full), 3);
        hold    = SRAM_address;
        changes = 0;
        writes  = 0;
        repeat (100) begin
            @(posedge Clock);
            #1;
            if (SRAM_address !== hold) changes++;
            if (Buf_we === 1'b1) writes++;
        end
        check("stall_addr_changes", changes, 0);
        check("stall_writes", writes, 0);
        check("stall_addr", 32'(hold), 79360);
        check("busy_during_stall", 32'(Busy), 1);
        manual_rel = 2'b01;
        @(posedge Clock);
        #1 manual_rel = 2'b00;
        check("bank0_released", 32'(Bank_full), 2);
        check("resume_addr0", 32'(SRAM_address), 79360);
        @(posedge Clock); #1 check("resume_addr1", 32'(SRAM_address), 79361);
        @(posedge Clock); #1 check("resume_no_write_yet", 32'(Buf_we), 0);
        @(posedge Clock); #1 check("resume_first_write", 32'(Buf_we), 1);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge Clock);
            #1 n++;
        end
        check("block2_written", exp_q.size(), 0);

        // reset mid-block aborts and discards in-flight reads
        reset_dut();
        auto_rel = 1'b1;
        push_block(0, 0);
        start_pulse();
        repeat (29) @(posedge Clock);
        #1 Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("midrst_buf_we", 32'(Buf_we), 0);
        check("midrst_bank_full", 32'(Bank_full), 0);
        check("midrst_busy", 32'(Busy), 0);
        check("midrst_sram_addr", 32'(SRAM_address), 0);
        exp_q.delete();
        writes = 0;
        repeat (4) begin
            @(posedge Clock);
            #1;
            if (Buf_we === 1'b1) writes++;
        end
        check("midrst_no_writes", writes, 0);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        run_full_image();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
